// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master arbiter/sequencer for the shared peripheral bus
// Ports: clk; rstB (asynchronous, active-low)
//   m0_*/m1_*  : master req/we/addr/wdata in; gnt/rvalid/rdata/rerr out
//   addr/wrData/wrEn/rdEn : registered bus request outputs
//   rdData/rdValid        : peripheral read return
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise m0 wins ties.
module io_bus_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rstB,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rerr,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rerr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrData,
  output logic              wrEn,
  output logic              rdEn,
  input  logic [DATA_W-1:0] rdData,
  input  logic              rdValid
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RWAIT = 2'd2;
  // the wait ends on the edge where the counter would reach TIMEOUT
  localparam logic [3:0] LAST = 4'(TIMEOUT - 1);
  logic [1:0] state;
  logic [3:0] cnt;
  logic owner, pick, selWe;
  logic [DATA_W-1:0] rsp;
`ifdef ARB_ROUND_ROBIN_EN
  logic lastWinner;
  always_comb pick = m1_req & (~m0_req | ~lastWinner);
  always_ff @(posedge clk or negedge rstB)
    if (!rstB) lastWinner <= 1'b1;
    else if (state == IDLE && (m0_req | m1_req)) lastWinner <= pick;
`else
  always_comb pick = ~m0_req;
`endif
  always_comb selWe = pick ? m1_we : m0_we;
  always_comb rsp = rdValid ? rdData : '1;
  always_ff @(posedge clk or negedge rstB)
    if (!rstB) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      addr      <= '0;
      wrData    <= '0;
      wrEn      <= 1'b0;
      rdEn      <= 1'b0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_rerr   <= 1'b0;
      m1_rerr   <= 1'b0;
    end else begin
      addr      <= '0;
      wrData    <= '0;
      wrEn      <= 1'b0;
      rdEn      <= 1'b0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_rerr   <= 1'b0;
      m1_rerr   <= 1'b0;
      if (state == IDLE) begin
        if (m0_req | m1_req) begin
          state  <= ISSUE;
          owner  <= pick;
          addr   <= pick ? m1_addr : m0_addr;
          wrData <= selWe ? (pick ? m1_wdata : m0_wdata) : '0;
          wrEn   <= selWe;
          rdEn   <= ~selWe;
          m0_gnt <= ~pick;
          m1_gnt <= pick;
        end
      end else if (state == ISSUE) begin
        state <= wrEn ? IDLE : RWAIT;
        cnt   <= '0;
      end else begin
        cnt <= (cnt == 4'hF) ? cnt : cnt + 4'd1;
        if (rdValid || cnt == LAST) begin
          state <= IDLE;
          if (owner) begin
            m1_rvalid <= 1'b1;
            m1_rdata  <= rsp;
            m1_rerr   <= ~rdValid;
          end else begin
            m0_rvalid <= 1'b1;
            m0_rdata  <= rsp;
            m0_rerr   <= ~rdValid;
          end
        end
      end
    end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: scoreboard bench for io_bus_arbiter
module tb_io_bus_arbiter;
  logic clk = 1'b0, rstB = 1'b0;
  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [10:0] m0_addr = '0, m1_addr = '0, addr;
  logic [31:0] m0_wdata = '0, m1_wdata = '0, wrData, rdData = '0;
  logic rdValid = 1'b0, wrEn, rdEn;
  logic m0_gnt, m0_rvalid, m0_rerr, m1_gnt, m1_rvalid, m1_rerr;
  logic [31:0] m0_rdata, m1_rdata;
  int checks = 0, failures = 0;
  typedef struct packed {logic who; logic we; logic [10:0] a; logic [31:0] d;} iss_t;
  typedef struct packed {logic who; logic [31:0] d; logic err;} rsp_t;
  iss_t iq[$];
  rsp_t rq[$];
  io_bus_arbiter dut (
    .clk(clk), .rstB(rstB),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rerr(m0_rerr),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rerr(m1_rerr),
    .addr(addr), .wrData(wrData), .wrEn(wrEn), .rdEn(rdEn),
    .rdData(rdData), .rdValid(rdValid)
  );
  always #5 clk = ~clk;
  task automatic doReset;
    rstB = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    rdValid = 1'b0;
    rdData = '0;
    repeat (2) @(negedge clk);
    rstB = 1'b1;
    @(negedge clk);
  endtask
  task automatic drive(input logic who, input logic we, input logic [10:0] a, input logic [31:0] d);
    if (who) begin
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
    end
    iq.push_back('{who, we, a, d});
  endtask
  task automatic waitGnt(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m0_gnt || m1_gnt) && n < 20);
  endtask
  task automatic waitRsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m0_rvalid || m1_rvalid) && n < 30);
  endtask
  task automatic test_reset;
    rstB = 1'b0;
    @(negedge clk);
    checks++;
    if ({addr, wrData, wrEn, rdEn} !== 45'h0) begin
      failures++; $display("FAIL reset_bus got=%h exp=0", {addr, wrData, wrEn, rdEn});
    end
    checks++;
    if ({m0_gnt, m0_rvalid, m0_rdata, m0_rerr} !== 35'h0) begin
      failures++; $display("FAIL reset_m0 got=%h exp=0", {m0_gnt, m0_rvalid, m0_rdata, m0_rerr});
    end
    checks++;
    if ({m1_gnt, m1_rvalid, m1_rdata, m1_rerr} !== 35'h0) begin
      failures++; $display("FAIL reset_m1 got=%h exp=0", {m1_gnt, m1_rvalid, m1_rdata, m1_rerr});
    end
    rstB = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_write;
    int n;
    iss_t e;
    logic [46:0] o, x;
    drive(1'b0, 1'b1, 11'h404, 32'h5A);
    waitGnt(n);
    e = iq.pop_front();
    o = {m0_gnt, m1_gnt, addr, wrData, wrEn, rdEn};
    x = {~e.who, e.who, e.a, e.we ? e.d : 32'h0, e.we, ~e.we};
    checks++;
    if (n !== 1) begin failures++; $display("FAIL wr_latency got=%0d exp=1", n); end
    checks++;
    if (o !== x) begin failures++; $display("FAIL wr_issue got=%h exp=%h", o, x); end
    m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt, wrEn, rdEn, addr} !== 15'h0) begin
      failures++; $display("FAIL wr_single_cycle got=%h exp=0", {m0_gnt, m1_gnt, wrEn, rdEn, addr});
    end
  endtask
  task automatic test_read_ok;
    int n;
    iss_t e;
    rsp_t r;
    logic [46:0] o, x;
    drive(1'b1, 1'b0, 11'h406, 32'h0);
    waitGnt(n);
    e = iq.pop_front();
    o = {m0_gnt, m1_gnt, addr, wrData, wrEn, rdEn};
    x = {~e.who, e.who, e.a, e.we ? e.d : 32'h0, e.we, ~e.we};
    checks++;
    if (o !== x) begin failures++; $display("FAIL rd_issue got=%h exp=%h", o, x); end
    m1_req = 1'b0;
    repeat (2) @(negedge clk);
    rdValid = 1'b1;
    rdData = 32'h0000_00C3;
    rq.push_back('{1'b1, 32'h0000_00C3, 1'b0});
    waitRsp(n);
    rdValid = 1'b0;
    rdData = '0;
    r = rq.pop_front();
    checks++;
    if (n !== 1) begin failures++; $display("FAIL rd_latency got=%0d exp=1", n); end
    checks++;
    if ({m1_rvalid, m1_rdata, m1_rerr} !== {1'b1, r.d, r.err}) begin
      failures++; $display("FAIL rd_resp got=%h exp=%h", {m1_rvalid, m1_rdata, m1_rerr}, {1'b1, r.d, r.err});
    end
    checks++;
    if ({m0_gnt, m0_rvalid, m0_rdata, m0_rerr} !== 35'h0) begin
      failures++; $display("FAIL rd_other_quiet got=%h exp=0", {m0_gnt, m0_rvalid, m0_rdata, m0_rerr});
    end
    @(negedge clk);
    checks++;
    if ({m1_rvalid, m1_rdata} !== 33'h0) begin
      failures++; $display("FAIL rd_pulse got=%h exp=0", {m1_rvalid, m1_rdata});
    end
  endtask
  task automatic test_timeout;
    int n;
    iss_t e;
    rsp_t r;
    drive(1'b0, 1'b0, 11'h7FF, 32'h0);
    waitGnt(n);
    e = iq.pop_front();
    checks++;
    if ({m0_gnt, addr, rdEn, wrEn} !== {~e.who, e.a, 1'b1, 1'b0}) begin
      failures++; $display("FAIL to_issue got=%h exp=%h", {m0_gnt, addr, rdEn, wrEn}, {~e.who, e.a, 1'b1, 1'b0});
    end
    m0_req = 1'b0;
    rq.push_back('{1'b0, 32'hFFFF_FFFF, 1'b1});
    waitRsp(n);
    r = rq.pop_front();
    checks++;
    if (n !== 5) begin failures++; $display("FAIL to_latency got=%0d exp=5", n); end
    checks++;
    if ({m0_rvalid, m0_rdata, m0_rerr} !== {1'b1, r.d, r.err}) begin
      failures++; $display("FAIL to_resp got=%h exp=%h", {m0_rvalid, m0_rdata, m0_rerr}, {1'b1, r.d, r.err});
    end
  endtask
  task automatic test_timeout_edge;
    int n;
    rsp_t r;
    drive(1'b1, 1'b0, 11'h123, 32'h0);
    waitGnt(n);
    void'(iq.pop_front());
    m1_req = 1'b0;
    repeat (4) @(negedge clk);
    rdValid = 1'b1;
    rdData = 32'hA5A5_5A5A;
    rq.push_back('{1'b1, 32'hA5A5_5A5A, 1'b0});
    waitRsp(n);
    rdValid = 1'b0;
    r = rq.pop_front();
    checks++;
    if (n !== 1) begin failures++; $display("FAIL edge_latency got=%0d exp=1", n); end
    checks++;
    if ({m1_rvalid, m1_rdata, m1_rerr} !== {1'b1, r.d, r.err}) begin
      failures++; $display("FAIL edge_resp got=%h exp=%h", {m1_rvalid, m1_rdata, m1_rerr}, {1'b1, r.d, r.err});
    end
  endtask
  task automatic test_stale;
    int n;
    rsp_t r;
    rdValid = 1'b1;
    rdData = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
        failures++; $display("FAIL stale_idle got=%b exp=00", {m0_rvalid, m1_rvalid});
      end
    end
    rdValid = 1'b0;
    drive(1'b0, 1'b0, 11'h055, 32'h0);
    waitGnt(n);
    void'(iq.pop_front());
    m0_req = 1'b0;
    rdValid = 1'b1;
    rdData = 32'h0000_BAD0;
    @(negedge clk);
    rdValid = 1'b0;
    checks++;
    if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL stale_issue1 got=%b exp=0", m0_rvalid); end
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL stale_issue2 got=%b exp=0", m0_rvalid); end
    rdValid = 1'b1;
    rdData = 32'h0000_1234;
    rq.push_back('{1'b0, 32'h0000_1234, 1'b0});
    waitRsp(n);
    rdValid = 1'b0;
    r = rq.pop_front();
    checks++;
    if ({n == 1, m0_rvalid, m0_rdata, m0_rerr} !== {1'b1, 1'b1, r.d, r.err}) begin
      failures++; $display("FAIL stale_resp got=%0d/%h exp=1/%h", n, {m0_rvalid, m0_rdata, m0_rerr}, {1'b1, r.d, r.err});
    end
  endtask
  task automatic test_arbitration;
    int n;
    iss_t e;
    logic [46:0] o, x;
    doReset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 11'h010; m0_wdata = 32'hA0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 11'h020; m1_wdata = 32'hB0;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (i % 2 == 0) iq.push_back('{1'b0, 1'b1, 11'h010, 32'hA0});
      else iq.push_back('{1'b1, 1'b1, 11'h020, 32'hB0});
`else
      iq.push_back('{1'b0, 1'b1, 11'h010, 32'hA0});
`endif
    end
    iq.push_back('{1'b1, 1'b1, 11'h020, 32'hB0});
    for (int i = 0; i < 5; i++) begin
      waitGnt(n);
      e = iq.pop_front();
      if (i == 4) m1_req = 1'b0;
      if (i == 3) m0_req = 1'b0;
      o = {m0_gnt, m1_gnt, addr, wrData, wrEn, rdEn};
      x = {~e.who, e.who, e.a, e.d, 1'b1, 1'b0};
      checks++;
      if (n !== (i == 0 ? 1 : 2)) begin failures++; $display("FAIL arb_rate[%0d] got=%0d exp=%0d", i, n, i == 0 ? 1 : 2); end
      checks++;
      if (o !== x) begin failures++; $display("FAIL arb_grant[%0d] got=%h exp=%h", i, o, x); end
    end
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    int n, seen;
    iss_t e;
    drive(1'b1, 1'b0, 11'h406, 32'h0);
    waitGnt(n);
    void'(iq.pop_front());
    m1_req = 1'b0;
    repeat (2) @(negedge clk);
    rdValid = 1'b1;
    rdData = 32'h0000_00C3;
    rstB = 1'b0;
    #1;
    checks++;
    if ({addr, wrData, wrEn, rdEn, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_rerr, m1_rerr} !== 115'h0) begin
      failures++; $display("FAIL rst_mid_zero got=%h exp=0", {addr, wrData, wrEn, rdEn, m1_rvalid, m1_rdata});
    end
    @(negedge clk);
    rdValid = 1'b0;
    rstB = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (m1_rvalid || m0_rvalid) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL rst_mid_dropped got=%0d exp=0", seen); end
    drive(1'b0, 1'b1, 11'h404, 32'h77);
    waitGnt(n);
    e = iq.pop_front();
    m0_req = 1'b0;
    checks++;
    if ({n == 1, m0_gnt, m1_gnt, addr, wrData, wrEn} !== {1'b1, 1'b1, 1'b0, e.a, e.d, 1'b1}) begin
      failures++; $display("FAIL rst_mid_regrant got=%0d/%h exp=1/%h", n, {m0_gnt, m1_gnt, addr, wrData, wrEn}, {1'b1, 1'b0, e.a, e.d, 1'b1});
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 11'h300, 32'h1);
    waitGnt(n);
    void'(iq.pop_front());
    m0_req = 1'b0;
    rstB = 1'b0;
    #1;
    checks++;
    if ({m0_gnt, wrEn, addr, wrData} !== 45'h0) begin
      failures++; $display("FAIL rst_async got=%h exp=0", {m0_gnt, wrEn, addr, wrData});
    end
    @(negedge clk);
    rstB = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_write();
    test_read_ok();
    test_timeout();
    test_timeout_edge();
    test_stale();
    test_arbitration();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
